pe_rst_seq: RTL and testbench

- Reset and power-up-contract sequencer sitting directly upstream of the processing element.
- Generates the PE reset line and drives the PE power-up contract bits.
- Samples board strap pins until they are stable, then latches them as the contract.
- Consumes the PE's RESET line output as a soft-reset request and re-sequences the PE, retaining the latched contract.

---
 rtl/pe_rst_seq.sv | 133 +++++++++++++
 tb/tb_pe_rst_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pe_rst_seq.sv
// PE reset sequencer: holds PE in reset, latches stable straps as the power-up contract, re-sequences on soft request.
// Outputs registered (change on the triggering edge); no backpressure, the soft request is edge-detected from a level.
module pe_rst_seq #(
  parameter int N_PUC         = 2,
  parameter int HOLD_CYCLES   = 16,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [N_PUC-1:0] strap_i,
  input  logic             pe_reset_req_i,
  output logic             pe_reset_o,
  output logic [N_PUC-1:0] puc_o,
  output logic             puc_valid_o,
  output logic [1:0]       rst_cause_o,
  output logic [CNT_W-1:0] rst_count_o
);

  localparam int MAX_C = (HOLD_CYCLES > STABLE_CYCLES) ? HOLD_CYCLES : STABLE_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [1:0] CAUSE_POR  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  typedef enum logic [1:0] {HOLD, SAMPLE, RUN, SOFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    hold_q, hold_d;
  logic [CW-1:0]    stab_q, stab_d;
  logic [N_PUC-1:0] sync1_q, strap_s, strap_prev;
  logic             req_prev;
  logic             pe_rst_q, pe_rst_d;
  logic [N_PUC-1:0] puc_q, puc_d;
  logic             vld_q, vld_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Strap synchroniser and request history run in every state.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync1_q    <= '0;
      strap_s    <= '0;
      strap_prev <= '0;
      req_prev   <= 1'b0;
    end else begin
      sync1_q    <= strap_i;
      strap_s    <= sync1_q;
      strap_prev <= strap_s;
      req_prev   <= pe_reset_req_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= HOLD;
      hold_q   <= '0;
      stab_q   <= '0;
      pe_rst_q <= 1'b0;
      puc_q    <= '0;
      vld_q    <= 1'b0;
      cause_q  <= CAUSE_POR;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      stab_q   <= stab_d;
      pe_rst_q <= pe_rst_d;
      puc_q    <= puc_d;
      vld_q    <= vld_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    stab_d   = stab_q;
    pe_rst_d = pe_rst_q;
    puc_d    = puc_q;
    vld_d    = vld_q;
    cause_d  = cause_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      HOLD: begin
        pe_rst_d = 1'b0;
        hold_d   = hold_q + CW'(1);
        if (hold_q == CW'(HOLD_CYCLES - 1)) state_d = SAMPLE;
      end
      SAMPLE: begin
        pe_rst_d = 1'b0;
        if (strap_s != strap_prev) begin
          stab_d = '0;
        end else if (stab_q == CW'(STABLE_CYCLES - 1)) begin
          stab_d   = '0;
          puc_d    = strap_s;
          vld_d    = 1'b1;
          pe_rst_d = 1'b1;
          state_d  = RUN;
        end else begin
          stab_d = stab_q + CW'(1);
        end
      end
      RUN: begin
        pe_rst_d = 1'b1;
        if (pe_reset_req_i && !req_prev) begin
          pe_rst_d = 1'b0;
          cause_d  = CAUSE_SOFT;
          hold_d   = '0;
          state_d  = SOFT;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SOFT: begin
        pe_rst_d = 1'b0;
        hold_d   = hold_q + CW'(1);
        if (hold_q == CW'(HOLD_CYCLES - 1)) begin
          pe_rst_d = 1'b1;
          state_d  = RUN;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  assign pe_reset_o  = pe_rst_q;
  assign puc_o       = puc_q;
  assign puc_valid_o = vld_q;
  assign rst_cause_o = cause_q;
  assign rst_count_o = cnt_q;

endmodule

// File: tb/tb_pe_rst_seq.sv
// Bench for pe_rst_seq: history-window reference model checked every cycle, plus directed literal checks.
module tb_pe_rst_seq;
  localparam int N    = 2;
  localparam int H    = 16;
  localparam int S    = 4;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;
  localparam int HMAX = 4096;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [N-1:0]  strap_i = 2'b10;
  logic          pe_reset_req_i = 1'b0;
  logic          pe_reset_o;
  logic [N-1:0]  puc_o;
  logic          puc_valid_o;
  logic [1:0]    rst_cause_o;
  logic [CW-1:0] rst_count_o;

  int errors = 0;
  int checks = 0;

  pe_rst_seq #(.N_PUC(N), .HOLD_CYCLES(H), .STABLE_CYCLES(S), .CNT_W(CW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .strap_i(strap_i), .pe_reset_req_i(pe_reset_req_i),
    .pe_reset_o(pe_reset_o), .puc_o(puc_o), .puc_valid_o(puc_valid_o),
    .rst_cause_o(rst_cause_o), .rst_count_o(rst_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
  endtask

  // Reference model: release happens on the first edge (k >= H+S) whose last S
  // synchroniser comparisons all saw equal straps; strap_s before edge k is strap_i
  // sampled at edge k-2, strap_prev is the one from edge k-3.
  int         edge_n = 0;
  int         soft_left = 0;
  bit         m_prev = 0, m_valid = 0, m_rst = 0, ok;
  int         m_cnt = 0;
  int         m_cause = 1;
  logic [N-1:0] m_puc = '0;
  logic [N-1:0] hist [0:HMAX-1];

  always @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      edge_n = 0; soft_left = 0; m_prev = 0; m_valid = 0; m_rst = 0;
      m_cnt = 0; m_cause = 1; m_puc = '0;
    end else begin
      edge_n++;
      if (edge_n < HMAX) hist[edge_n] = strap_i;
      if (!m_valid) begin
        if (edge_n >= H + S && edge_n < HMAX) begin
          ok = 1;
          for (int j = 0; j < S; j++)
            if (hist[edge_n-j-2] != hist[edge_n-j-3]) ok = 0;
          if (ok) begin
            m_valid = 1; m_rst = 1; m_puc = hist[edge_n-2];
          end
        end
      end else if (soft_left > 0) begin
        soft_left--;
        if (soft_left == 0) m_rst = 1;
      end else if (pe_reset_req_i && !m_prev) begin
        soft_left = H; m_rst = 0; m_cause = 2;
        if (m_cnt < MAXC) m_cnt++;
      end
      m_prev = pe_reset_req_i;
    end
  end

  always @(negedge clk_i) begin
    if (reset_i) begin
      check("m_pe_reset", pe_reset_o, m_rst);
      check("m_puc", puc_o, m_puc);
      check("m_puc_valid", puc_valid_o, m_valid);
      check("m_cause", rst_cause_o, m_cause);
      check("m_count", rst_count_o, m_cnt);
    end
  end

  initial begin
    #3 reset_i = 1'b0;
    tick(2);
    check("rst_pe_reset", pe_reset_o, 0);
    check("rst_puc_valid", puc_valid_o, 0);
    check("rst_puc", puc_o, 0);
    check("rst_cause", rst_cause_o, 1);
    check("rst_count", rst_count_o, 0);
    reset_i = 1'b1;

    // Power-on with constant straps: release on edge H+S.
    for (int k = 1; k <= H + S; k++) begin
      tick(1);
      check("por_release", pe_reset_o, (k == H + S) ? 1 : 0);
    end
    check("por_puc", puc_o, 2);
    check("por_valid", puc_valid_o, 1);
    check("por_cause", rst_cause_o, 1);

    // Single-cycle soft request.
    tick(3);
    pe_reset_req_i = 1'b1;
    tick(1);
    check("soft_entry", pe_reset_o, 0);
    pe_reset_req_i = 1'b0;
    for (int i = 1; i <= H; i++) begin
      tick(1);
      check("soft_len", pe_reset_o, (i == H) ? 1 : 0);
    end
    check("soft_cause", rst_cause_o, 2);
    check("soft_count", rst_count_o, 1);
    check("soft_puc", puc_o, 2);

    // Long request level plus strap change in RUN: one soft reset only.
    tick(3);
    strap_i = 2'b01;
    pe_reset_req_i = 1'b1;
    tick(40);
    pe_reset_req_i = 1'b0;
    tick(5);
    check("level_count", rst_count_o, 2);
    check("level_puc", puc_o, 2);
    check("level_rst", pe_reset_o, 1);

    // Reset asserted in the 5th SOFT cycle.
    tick(3);
    pe_reset_req_i = 1'b1;
    tick(1);
    pe_reset_req_i = 1'b0;
    tick(4);
    #2 reset_i = 1'b0;
    strap_i = 2'b10;
    #1;
    check("mid_pe_reset", pe_reset_o, 0);
    check("mid_valid", puc_valid_o, 0);
    check("mid_count", rst_count_o, 0);
    check("mid_cause", rst_cause_o, 1);
    check("mid_puc", puc_o, 0);
    tick(2);
    reset_i = 1'b1;

    // Strap toggles before edge 18 (2nd SAMPLE cycle): release moves to edge 24.
    tick(17);
    check("tog_hold", pe_reset_o, 0);
    strap_i = 2'b01;
    for (int k = 18; k <= 24; k++) begin
      tick(1);
      check("tog_release", pe_reset_o, (k == 24) ? 1 : 0);
    end
    check("tog_puc", puc_o, 1);
    check("tog_valid", puc_valid_o, 1);

    // 260 soft requests saturate the counter; straps changing meanwhile are ignored.
    strap_i = 2'b10;
    for (int p = 0; p < 260; p++) begin
      pe_reset_req_i = 1'b1;
      tick(1);
      pe_reset_req_i = 1'b0;
      tick(H + 1);
    end
    check("sat_count", rst_count_o, 255);
    check("sat_cause", rst_cause_o, 2);
    check("sat_puc", puc_o, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
